sign_ext: RTL and testbench



---
 rtl/sign_ext_pkg.sv | 7 +
 rtl/sign_ext_core.sv | 16 +
 rtl/sign_ext.sv | 50 +++++
 tb/tb_sign_ext.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sign_ext_pkg.sv
// sign_ext_pkg: shared mode constants and default widths for the immediate-extension stage
package sign_ext_pkg;
    localparam logic SEXT_MODE_ZERO = 1'b0;
    localparam logic SEXT_MODE_SIGN = 1'b1;
    localparam int IMM_W = 6;
    localparam int DATA_W = 16;
endpackage

// File: rtl/sign_ext_core.sv
// sign_ext_core: combinational zero/sign extension of an immediate field
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_W = IMM_W,
    parameter int OUT_W = DATA_W
) (
    input  logic [IN_W-1:0]  imm,
    input  logic             mode,
    output logic [OUT_W-1:0] ext,
    output logic             neg
);
    // the fill bit is exactly the negative flag: set only in sign mode with msb high
    assign neg = (mode == SEXT_MODE_SIGN) & imm[IN_W-1];
    assign ext = {{(OUT_W-IN_W){neg}}, imm};
endmodule

// File: rtl/sign_ext.sv
// sign_ext: registered immediate extension aligned to the ID/EX boundary
// SIGN_EXT_BYPASS_EN adds the combinational out16_comb forwarding port
module sign_ext
    import sign_ext_pkg::*;
#(
    parameter int IN_W = IMM_W,
    parameter int OUT_W = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in6,
    input  logic             sign_extension_mode,
    output logic [OUT_W-1:0] out16,
    output logic             out_valid,
`ifdef SIGN_EXT_BYPASS_EN
    output logic             out_neg,
    output logic [OUT_W-1:0] out16_comb
`else
    output logic             out_neg
`endif
);
    logic [OUT_W-1:0] ext;
    logic             neg;

    sign_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm (in6),
        .mode(sign_extension_mode),
        .ext (ext),
        .neg (neg)
    );

`ifdef SIGN_EXT_BYPASS_EN
    assign out16_comb = ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out16     <= '0;
            out_neg   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out16   <= ext;
                out_neg <= neg;
            end
        end
    end
endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: scoreboard bench for sign_ext against an arithmetic reference model
module tb_sign_ext;
    logic        clk = 1'b0;
    logic        rst, in_valid, mode;
    logic [5:0]  in6;
    logic [15:0] out16;
    logic        out_valid, out_neg;
`ifdef SIGN_EXT_BYPASS_EN
    logic [15:0] out16_comb;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        v;
        logic        n;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    sign_ext dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in6(in6),
        .sign_extension_mode(mode),
        .out16(out16),
        .out_valid(out_valid),
`ifdef SIGN_EXT_BYPASS_EN
        .out_neg(out_neg),
        .out16_comb(out16_comb)
`else
        .out_neg(out_neg)
`endif
    );

    always #5 clk = ~clk;

    // value interpreted as an unsigned or two's-complement 6-bit number, then written as 16 bits
    function automatic exp_t ref_ext(input logic [5:0] x, input logic m);
        int val;
        exp_t r;
        val = int'(x);
        if (m && val >= 32) val = val - 64;
        r.d = 16'(val);
        r.v = 1'b1;
        r.n = (val < 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [5:0] x, input logic m);
        rst = r;
        in_valid = v;
        in6 = x;
        mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t st, e;
        st = '0;
        forever begin
            @(posedge clk);
            if (rst) st = '0;
            else begin
                if (in_valid) begin
                    e = ref_ext(in6, mode);
                    st.d = e.d;
                    st.n = e.n;
                end
                st.v = in_valid;
            end
            q.push_back(st);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out16", out16, e.d);
                check("out_valid", 16'(out_valid), 16'(e.v));
                check("out_neg", 16'(out_neg), 16'(e.n));
            end
`ifdef SIGN_EXT_BYPASS_EN
            e = ref_ext(in6, mode);
            check("out16_comb", out16_comb, e.d);
`endif
        end
    end

    initial begin
        int waited;
        step(1, 1, 6'b111111, 1);
        step(1, 1, 6'b111111, 1);
        step(0, 1, 6'b111111, 0);
        step(0, 1, 6'b111111, 1);
        step(0, 1, 6'b100000, 1);
        step(0, 1, 6'b011111, 1);
        step(0, 1, 6'b000000, 1);
        step(0, 1, 6'b101010, 1);
        step(0, 0, 6'b010101, 0);
        step(0, 0, 6'b111000, 1);
        step(0, 1, 6'b110000, 1);
        step(1, 1, 6'b100001, 1);
        step(0, 1, 6'b100001, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(29) == 0, $urandom_range(9) < 7, 6'($urandom), 1'($urandom));
        for (int i = 0; i < 128; i++)
            step(0, 1, 6'(i), 1'(i >> 6));
        step(0, 0, 6'd0, 0);
        step(0, 0, 6'd0, 0);
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #2;
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d results left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
